// File: rtl/dunc16_seq_pkg.sv
// Shared types and constants for the DUNC16 instruction sequencer.
// Holds the run-state and major-state encodings plus the phase-ring helper.
package dunc16_seq_pkg;

    localparam int PHASES = 4;
    localparam logic [PHASES-1:0] PHASE_T0 = 4'b0001;

    typedef enum logic [1:0] {
        RS_HALT = 2'd0,
        RS_RUN  = 2'd1,
        RS_STEP = 2'd2
    } run_state_t;

    typedef enum logic [0:0] {
        MS_FETCH   = 1'b0,
        MS_EXECUTE = 1'b1
    } major_state_t;

    function automatic logic [PHASES-1:0] rotate_phase(input logic [PHASES-1:0] p);
        return {p[PHASES-2:0], p[PHASES-1]};
    endfunction

endpackage

// File: rtl/dunc16_phase_ring.sv
// One-hot timing-phase ring; the synchronous clear parks it on T0.
// phase_next is exposed so the parent can register decoded outputs.
module dunc16_phase_ring
    import dunc16_seq_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    output logic [PHASES-1:0] phase,
    output logic [PHASES-1:0] phase_next
);

    // next-phase selection: clear beats advance
    always_comb begin
        phase_next = phase;
        if (clr) begin
            phase_next = PHASE_T0;
        end else if (en) begin
            phase_next = rotate_phase(phase);
        end else begin
            phase_next = phase;
        end
    end

    // phase register
    always_ff @(posedge clk) begin
        phase <= phase_next;
    end

endmodule

// File: rtl/dunc16_sequencer.sv
// DUNC16 major-state / timing sequencer with run, step and stop control.
// Every output is a flop loaded from the next-state decode.
module dunc16_sequencer
    import dunc16_seq_pkg::*;
#(
    parameter bit START_RUNNING = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RUN,
    input  logic STOP,
    input  logic STEP,
    input  logic I_STA,
    input  logic I_HLT,
    output logic FETCH,
    output logic EXECUTE,
    output logic T0,
    output logic T1,
    output logic T2,
    output logic T3,
    output logic SETWRITE,
    output logic CLRWRITE,
    output logic WRITE,
    output logic RUNNING,
    output logic INSTR_DONE
);

    run_state_t        run_state_r;
    run_state_t        run_next_s;
    major_state_t      major_r;
    major_state_t      major_next_s;
    logic [PHASES-1:0] phase_s;
    logic [PHASES-1:0] phase_next_s;
    logic [PHASES-1:0] t_r;
    logic              stop_pending_r;
    logic              fetch_r, execute_r, running_r;
    logic              setwrite_r, clrwrite_r, write_r, instr_done_r;
    logic              active_s, exec_s, end_of_instr_s, halt_req_s;
    logic              going_halt_s, ring_clr_s;

    assign active_s       = (run_state_r != RS_HALT);
    assign exec_s         = active_s && (major_r == MS_EXECUTE);
    assign end_of_instr_s = exec_s && phase_s[PHASES-1];
    // A STOP arriving in E-T3 itself counts as well as one latched earlier
    assign halt_req_s     = stop_pending_r || STOP || (run_state_r == RS_STEP) || I_HLT;
    assign going_halt_s   = (run_next_s == RS_HALT);
    assign ring_clr_s     = RESET || going_halt_s;

    dunc16_phase_ring u_ring (
        .clk        (CLK),
        .clr        (ring_clr_s),
        .en         (active_s),
        .phase      (phase_s),
        .phase_next (phase_next_s)
    );

    // run-state transitions: STOP beats RUN beats STEP when starting
    always_comb begin
        run_next_s = run_state_r;
        case (run_state_r)
            RS_HALT: begin
                if (STOP) begin
                    run_next_s = RS_HALT;
                end else if (RUN) begin
                    run_next_s = RS_RUN;
                end else if (STEP) begin
                    run_next_s = RS_STEP;
                end else begin
                    run_next_s = RS_HALT;
                end
            end
            RS_RUN, RS_STEP: begin
                if (end_of_instr_s && halt_req_s) begin
                    run_next_s = RS_HALT;
                end else begin
                    run_next_s = run_state_r;
                end
            end
            default: run_next_s = RS_HALT;
        endcase
    end

    // major state flips after every T3 and parks on FETCH while halted
    always_comb begin
        major_next_s = major_r;
        if (going_halt_s) begin
            major_next_s = MS_FETCH;
        end else if (active_s && phase_s[PHASES-1]) begin
            major_next_s = (major_r == MS_FETCH) ? MS_EXECUTE : MS_FETCH;
        end else begin
            major_next_s = major_r;
        end
    end

    // state, write flip-flop and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            run_state_r    <= START_RUNNING ? RS_RUN : RS_HALT;
            major_r        <= MS_FETCH;
            stop_pending_r <= 1'b0;
            running_r      <= START_RUNNING;
            fetch_r        <= START_RUNNING;
            execute_r      <= 1'b0;
            t_r            <= START_RUNNING ? PHASE_T0 : 4'b0000;
            setwrite_r     <= 1'b0;
            clrwrite_r     <= 1'b0;
            write_r        <= 1'b0;
            instr_done_r   <= 1'b0;
        end else begin
            run_state_r    <= run_next_s;
            major_r        <= major_next_s;
            stop_pending_r <= going_halt_s ? 1'b0 : (stop_pending_r || STOP);
            running_r      <= !going_halt_s;
            fetch_r        <= !going_halt_s && (major_next_s == MS_FETCH);
            execute_r      <= !going_halt_s && (major_next_s == MS_EXECUTE);
            t_r            <= going_halt_s ? 4'b0000 : phase_next_s;
            // strobes are decoded one phase early so they land in E-T1 / E-T3
            setwrite_r     <= exec_s && phase_s[0] && I_STA;
            clrwrite_r     <= exec_s && phase_s[2] && write_r;
            instr_done_r   <= exec_s && phase_s[2];
            write_r        <= setwrite_r ? 1'b1 : (clrwrite_r ? 1'b0 : write_r);
        end
    end

    assign FETCH      = fetch_r;
    assign EXECUTE    = execute_r;
    assign T0         = t_r[0];
    assign T1         = t_r[1];
    assign T2         = t_r[2];
    assign T3         = t_r[3];
    assign SETWRITE   = setwrite_r;
    assign CLRWRITE   = clrwrite_r;
    assign WRITE      = write_r;
    assign RUNNING    = running_r;
    assign INSTR_DONE = instr_done_r;

endmodule
